// File: rtl/neg_mac_pkg.sv
// neg_mac_pkg: shared types, limits and helpers for the pipelined signed MAC.
// NEG_MAC_SAT_EN (consumed in neg_mac_acc) selects saturating accumulation.
package neg_mac_pkg;

  localparam int PIPE_MIN = 2;
  localparam int PIPE_MAX = 8;
  localparam int SAT_W    = 128;

  typedef struct packed {
    logic neg;
    logic acc_en;
  } ctl_t;

  function automatic bit cfg_ok(
    input int pipe,
    input int accw,
    input int mw
  );
    return (pipe >= PIPE_MIN) && (pipe <= PIPE_MAX) &&
           (accw >= mw) && (accw < SAT_W);
  endfunction

  // Operands arrive sign-extended to SAT_W, so the wide sum is exact;
  // overflow means it no longer fits a signed width-bit value.
  function automatic logic [SAT_W:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      width
  );
    logic signed [SAT_W-1:0] s;
    logic                    o;
    s = a + b;
    o = 1'b0;
    for (int i = 0; i < SAT_W; i++) begin
      if (i >= width && s[i] != s[width-1]) o = 1'b1;
    end
    return {s, o};
  endfunction

endpackage

// File: rtl/neg_mac_pipe_if.sv
// neg_mac_pipe_if: input beat and output beat handshakes of the MAC.
// master = beat producer / result consumer, slave = the MAC itself.
interface neg_mac_pipe_if #(
  parameter int AW   = 27,
  parameter int BW   = 24,
  parameter int ACCW = 58
);

  localparam int MW = AW + BW;

  logic                   in_valid;
  logic                   in_ready;
  logic signed [AW-1:0]   ain;
  logic signed [BW-1:0]   bin;
  logic                   neg;
  logic                   acc_en;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [MW-1:0]   prod;
  logic signed [ACCW-1:0] acc;
  logic                   ovf;

  modport master (
    output in_valid, ain, bin, neg, acc_en, out_ready,
    input  in_ready, out_valid, prod, acc, ovf
  );

  modport slave (
    input  in_valid, ain, bin, neg, acc_en, out_ready,
    output in_ready, out_valid, prod, acc, ovf
  );

endinterface

// File: rtl/neg_mac_acc.sv
// neg_mac_acc: final accumulate/output stage with sticky overflow.
// Saturates under NEG_MAC_SAT_EN, otherwise wraps two's-complement.
module neg_mac_acc
  import neg_mac_pkg::*;
#(
  parameter int MW   = 51,
  parameter int ACCW = 58
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   adv_i,
  input  logic                   valid_i,
  input  logic signed [MW-1:0]   prod_i,
  input  ctl_t                   ctl_i,
  output logic                   valid_o,
  output logic signed [MW-1:0]   prod_o,
  output logic signed [ACCW-1:0] acc_o,
  output logic                   ovf_o
);

  logic                   valid_q;
  logic signed [MW-1:0]   prod_q;
  logic signed [ACCW-1:0] acc_q;
  logic                   ovf_q;

  logic signed [ACCW-1:0] base;
  logic [SAT_W:0]         sum_r;
  logic signed [ACCW-1:0] acc_d;
  logic                   hit;
  logic                   unused_bits;

  assign unused_bits = ^{sum_r[SAT_W:ACCW+1], ctl_i.neg};

  always_comb begin
    base  = ctl_i.acc_en ? acc_q : '0;
    sum_r = sat_add(SAT_W'(base), SAT_W'(prod_i), ACCW);
    hit   = sum_r[0];
    acc_d = sum_r[ACCW:1];
`ifdef NEG_MAC_SAT_EN
    // Sign of the exact wide sum picks the rail.
    if (hit) begin
      acc_d = sum_r[SAT_W] ? {1'b1, {(ACCW-1){1'b0}}}
                           : {1'b0, {(ACCW-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      prod_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (adv_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        prod_q <= prod_i;
        acc_q  <= acc_d;
        ovf_q  <= ovf_q | hit;
      end
    end
  end

  assign valid_o = valid_q;
  assign prod_o  = prod_q;
  assign acc_o   = acc_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/neg_mac_pipe.sv
// neg_mac_pipe: pipelined signed multiply-accumulate with per-beat negate.
// Build option NEG_MAC_SAT_EN: saturating accumulator (see neg_mac_acc).
module neg_mac_pipe
  import neg_mac_pkg::*;
#(
  parameter int AW   = 27,
  parameter int BW   = 24,
  parameter int ACCW = 58,
  parameter int PIPE = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  neg_mac_pipe_if.slave  bus
);

  localparam int MW   = AW + BW;
  localparam int MSTG = PIPE - 2;

  if (!cfg_ok(PIPE, ACCW, MW)) begin : g_bad_cfg
    $error("neg_mac_pipe: PIPE or ACCW out of range");
  end

  logic adv;
  logic take;

  logic                 out_valid;
  logic signed [MW-1:0] out_prod;

  // One global enable: the whole pipe moves or the whole pipe holds.
  assign adv          = !out_valid || bus.out_ready;
  assign bus.in_ready = adv && !clr && rst_n;
  assign take         = bus.in_valid && bus.in_ready;

  logic                 v1_q;
  logic signed [AW-1:0] a1_q;
  logic signed [BW-1:0] b1_q;
  ctl_t                 c1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      c1_q <= '0;
    end else if (clr) begin
      v1_q <= 1'b0;
    end else if (adv) begin
      v1_q <= take;
      if (take) begin
        a1_q <= bus.ain;
        b1_q <= bus.bin;
        c1_q <= '{neg: bus.neg, acc_en: bus.acc_en};
      end
    end
  end

  logic signed [MW-1:0] ax;
  logic signed [MW-1:0] bx;
  logic signed [MW-1:0] mul;
  logic signed [MW-1:0] p1;

  assign ax  = MW'(a1_q);
  assign bx  = MW'(b1_q);
  assign mul = ax * bx;
  assign p1  = c1_q.neg ? -mul : mul;

  logic                 vm;
  logic signed [MW-1:0] pm;
  ctl_t                 cm;

  if (MSTG == 0) begin : g_fold
    assign vm = v1_q;
    assign pm = p1;
    assign cm = c1_q;
  end else begin : g_mul
    logic [MSTG-1:0]      v_q;
    logic signed [MW-1:0] p_q [MSTG];
    ctl_t                 c_q [MSTG];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int i = 0; i < MSTG; i++) begin
          p_q[i] <= '0;
          c_q[i] <= '0;
        end
      end else if (clr) begin
        v_q <= '0;
      end else if (adv) begin
        v_q[0] <= v1_q;
        p_q[0] <= p1;
        c_q[0] <= c1_q;
        for (int i = 1; i < MSTG; i++) begin
          v_q[i] <= v_q[i-1];
          p_q[i] <= p_q[i-1];
          c_q[i] <= c_q[i-1];
        end
      end
    end

    assign vm = v_q[MSTG-1];
    assign pm = p_q[MSTG-1];
    assign cm = c_q[MSTG-1];
  end

  logic signed [ACCW-1:0] out_acc;
  logic                   out_ovf;

  neg_mac_acc #(
    .MW   (MW),
    .ACCW (ACCW)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .adv_i   (adv),
    .valid_i (vm),
    .prod_i  (pm),
    .ctl_i   (cm),
    .valid_o (out_valid),
    .prod_o  (out_prod),
    .acc_o   (out_acc),
    .ovf_o   (out_ovf)
  );

  assign bus.out_valid = out_valid;
  assign bus.prod      = out_prod;
  assign bus.acc       = out_acc;
  assign bus.ovf       = out_ovf;

endmodule
